lsu_bus_ctrl: RTL

Load/store unit between the ALU/control stage and the data-memory bus of the single-cycle RISC-V core. It turns a load/store request (ALU address, rs2 data, funct3) into a req/ack bus transaction with byte enables. It stalls the core until the bus acknowledges. Load data is returned right-aligned (selected lane shifted to bit 0) on `mem_data`, which feeds the write-back select/extend mux directly; sign/zero extension is not done here.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu_bus_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: constants and types shared across the load/store unit.
//   - funct3 access-size codes used by the lane aligner.
//   - 2-bit FSM state type used by lsu_bus_ctrl.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for the load/store unit.
// Ports:
//   funct3_i     access size code (B/H/W/BU/HU, others illegal)
//   addr_lo_i    byte offset of the current request
//   wdata_i      store data (rs2)
//   rd_off_i     byte offset of the load being completed
//   rdata_i      full bus read word
//   be_o         byte enables for the current request
//   wdata_rep_o  store data replicated across all lanes
//   misalign_o   request misaligned or funct3 illegal (ungated)
//   rdata_al_o   read word shifted so the addressed lane sits at bit 0
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic        misalign_o,
  output logic [31:0] rdata_al_o
);

  always_comb begin
    be_o        = '0;
    wdata_rep_o = '0;
    misalign_o  = 1'b1;
    unique case (funct3_i)
      F3_B, F3_BU: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        misalign_o  = 1'b0;
      end
      F3_H, F3_HU: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
        misalign_o  = addr_lo_i[0];
      end
      F3_W: begin
        be_o        = '1;
        wdata_rep_o = wdata_i;
        misalign_o  = |addr_lo_i;
      end
      default: begin
        be_o        = '0;
        wdata_rep_o = '0;
        misalign_o  = 1'b1;
      end
    endcase
  end

  // Zero-filled right shift; extension is left to the write-back mux.
  assign rdata_al_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bridging the core to a req/ack data bus.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_read, mem_write     load / store request from the current instruction
//   funct3, addr, wdata     access size, byte address, store data
//   stall                   hold PC and register-file write while high
//   mem_data                right-aligned load data (registered)
//   misalign                combinational misalign/illegal-size flag
//   timeout                 one-cycle pulse in the DONE cycle after an abort
//   bus_req, bus_we         registered bus request and direction
//   bus_addr, bus_be        registered word address and byte enables
//   bus_wdata               registered lane-replicated store data
//   bus_ack, bus_rdata      bus completion and read word
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] mem_data,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] mem_data_q;
  logic        timeout_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;
  logic        mis_raw;
  logic        req_any;
  logic        go;
  logic [7:0]  cnt_d;

  lsu_lane_align u_align (
    .funct3_i    (funct3),
    .addr_lo_i   (addr[1:0]),
    .wdata_i     (wdata),
    .rd_off_i    (off_q),
    .rdata_i     (bus_rdata),
    .be_o        (be_d),
    .wdata_rep_o (wdata_d),
    .misalign_o  (mis_raw),
    .rdata_al_o  (rdata_d)
  );

  assign req_any  = mem_read | mem_write;
  assign misalign = req_any & mis_raw;
  assign go       = req_any & ~mis_raw;
  assign cnt_d    = cnt_q + 8'd1;

  // Gated by rst_n so a reset mid-request releases the core at once,
  // even while the request inputs are still asserted.
  assign stall = rst_n & (((state_q == ST_IDLE) & go) | (state_q == ST_REQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      mem_data_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= ~mem_read;  // load wins if both are set
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= mem_read ? '0 : wdata_d;
            off_q       <= addr[1:0];
            cnt_q       <= '0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) mem_data_q <= rdata_d;
            state_q   <= ST_DONE;
          end else if (cnt_d == 8'(TIMEOUT)) begin
            bus_req_q <= 1'b0;
            timeout_q <= 1'b1;
            if (!bus_we_q) mem_data_q <= '0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_data  = mem_data_q;
  assign timeout   = timeout_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
